// File: rtl/branch_sequencer_pkg.sv
// Shared constants, IR field positions and FSM state type
// for the branch sequencer (optional feature macro: BR_STATS_EN).
package branch_sequencer_pkg;

    localparam logic [4:0] OP_BR = 5'b10010;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int C2_HI  = 22;
    localparam int C2_LO  = 19;
    localparam int C_HI   = 18;
    localparam int C_LO   = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COND   = 2'd1,
        EVAL   = 2'd2,
        COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/branch_sequencer_if.sv
// Control-unit <-> branch sequencer signal bundle.
// master = control unit side, slave = sequencer side.
interface branch_sequencer_if;

    logic        start;
    logic [31:0] ir;
    logic        pc_incr;
    logic        con_ff;
    logic        con_in;
    logic [3:0]  c2_field;
    logic [3:0]  ra_sel;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    logic        taken;
    logic        err;

    modport master (
        output start, ir, pc_incr, con_ff,
        input  con_in, c2_field, ra_sel, pc, busy, done, taken, err
    );

    modport slave (
        input  start, ir, pc_incr, con_ff,
        output con_in, c2_field, ra_sel, pc, busy, done, taken, err
    );

endinterface

// File: rtl/branch_sequencer_br_target_adder.sv
// Branch target: base + sign-extended offset, modulo 2^32.
// Purely combinational.
module br_target_adder #(
    parameter int OFFSET_W = 19
) (
    input  logic [31:0]         base,
    input  logic [OFFSET_W-1:0] offset,
    output logic [31:0]         target
);

    logic [31:0] offset_ext;

    assign offset_ext = {{(32 - OFFSET_W){offset[OFFSET_W-1]}}, offset};
    assign target = base + offset_ext;

endmodule

// File: rtl/branch_sequencer.sv
// Conditional branch sequencer: COND -> EVAL -> COMMIT, owns the PC.
// Define BR_STATS_EN to add the saturating br_taken_cnt output.
import branch_sequencer_pkg::*;

module branch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          OFFSET_W = 19
) (
    input  logic              clk,
    input  logic              clr,
`ifdef BR_STATS_EN
    branch_sequencer_if.slave bus,
    output logic [15:0]       br_taken_cnt
`else
    branch_sequencer_if.slave bus
`endif
);

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc_q;
    logic [31:0] target;
    logic [31:0] target_q;
    logic        con_q;
    logic        err_q;
    logic [3:0]  c2_q;
    logic [3:0]  ra_q;
    logic        is_br;
    logic        go;
    logic        bad;

    assign is_br = (bus.ir[OPC_HI:OPC_LO] == OP_BR);
    assign go    = (state == IDLE) && bus.start && is_br;
    assign bad   = (state == IDLE) && bus.start && !is_br;

    br_target_adder #(
        .OFFSET_W (OFFSET_W)
    ) u_adder (
        .base   (pc_q),
        .offset (bus.ir[OFFSET_W-1:0]),
        .target (target)
    );

    // Next-state: a branch always walks COND, EVAL, COMMIT then idles
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = go ? COND : IDLE;
            COND:    state_nx = EVAL;
            EVAL:    state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    end

    // PC: load target on taken commit, otherwise increment only when idle
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            pc_q <= RESET_PC;
        else if (state == COMMIT && con_q)
            pc_q <= target_q;
        else if (state == IDLE && bus.pc_incr)
            pc_q <= pc_q + 32'd1;
    end

    // Capture Ra and C2 selects when a branch is accepted
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            c2_q <= '0;
            ra_q <= '0;
        end else if (go) begin
            c2_q <= bus.ir[C2_HI:C2_LO];
            ra_q <= bus.ir[RA_HI:RA_LO];
        end
    end

    // EVAL samples the condition and freezes the target
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            con_q    <= 1'b0;
            target_q <= '0;
        end else if (state == EVAL) begin
            con_q    <= bus.con_ff;
            target_q <= target;
        end
    end

    // Illegal-opcode start raises err for the following cycle
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) err_q <= 1'b0;
        else      err_q <= bad;
    end

`ifdef BR_STATS_EN
    // Saturating count of taken branches
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            br_taken_cnt <= '0;
        else if (state == COMMIT && con_q && br_taken_cnt != 16'hFFFF)
            br_taken_cnt <= br_taken_cnt + 16'd1;
    end
`endif

    assign bus.pc       = pc_q;
    assign bus.c2_field = c2_q;
    assign bus.ra_sel   = ra_q;
    assign bus.busy     = (state != IDLE);
    assign bus.con_in   = (state == COND);
    assign bus.done     = (state == COMMIT);
    assign bus.taken    = (state == COMMIT) && con_q;
    assign bus.err      = err_q;

endmodule
